// File: rtl/foreach_pkg.sv
// Shared types and index helper for the foreach sum sequencer.
package foreach_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fe_state_t;

  typedef enum logic {
    SUM     = 1'b0,
    INC_SUM = 1'b1
  } fe_mode_t;

  // Row-major flattening; dims passed in so the package stays parameter-free.
  function automatic int flat_idx(input int i, input int j, input int k,
                                  input int d1, input int d2);
    return i * d1 * d2 + j * d2 + k;
  endfunction

endpackage

// File: rtl/foreach_idx_counter.sv
// Three-level nested index counter; k is fastest and carries into j, then i.
module foreach_idx_counter #(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4,
  parameter int IW = 1,
  parameter int JW = 2,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [KW-1:0] k,
  output logic          last
);

  logic i_wrap, j_wrap, k_wrap;

  assign i_wrap = (i == IW'(D0 - 1));
  assign j_wrap = (j == JW'(D1 - 1));
  assign k_wrap = (k == KW'(D2 - 1));
  assign last   = i_wrap && j_wrap && k_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (en) begin
      if (k_wrap) begin
        k <= '0;
        if (j_wrap) begin
          j <= '0;
          i <= i_wrap ? '0 : i + IW'(1);
        end else begin
          j <= j + JW'(1);
        end
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule

// File: rtl/foreach_sum_ctrl.sv
// Walks a D0xD1xD2 register array row-major, one element per cycle,
// accumulating a signed sum with optional in-place increment.
module foreach_sum_ctrl
  import foreach_pkg::*;
#(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4,
  parameter int W  = 32,
  parameter int SW = W + $clog2(D0 * D1 * D2 + 1),
  localparam int IW = (D0 > 1) ? $clog2(D0) : 1,
  localparam int JW = (D1 > 1) ? $clog2(D1) : 1,
  localparam int KW = (D2 > 1) ? $clog2(D2) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_i,
  input  logic [JW-1:0]        wr_j,
  input  logic [KW-1:0]        wr_k,
  input  logic [W-1:0]         wr_data,
  input  logic [IW-1:0]        rd_i,
  input  logic [JW-1:0]        rd_j,
  input  logic [KW-1:0]        rd_k,
  output logic [W-1:0]         rd_data,
  output logic                 busy,
  output logic                 done,
  output logic signed [SW-1:0] sum
);

  localparam int N  = D0 * D1 * D2;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  fe_state_t state, state_nxt;
  fe_mode_t  mode_q;

  logic [W-1:0]         mem [N];
  logic [IW-1:0]        ci;
  logic [JW-1:0]        cj;
  logic [KW-1:0]        ck;
  logic                 last;
  logic                 accept, run;
  logic                 wr_ok, rd_ok;
  logic [AW-1:0]        cur_addr, wr_addr, rd_addr;
  logic [W-1:0]         elem, elem_new;
  logic signed [SW-1:0] acc, acc_nxt;

  assign accept = (state == IDLE) && start;
  assign run    = (state == RUN);

  foreach_idx_counter #(
    .D0(D0), .D1(D1), .D2(D2), .IW(IW), .JW(JW), .KW(KW)
  ) u_idx (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (run),
    .i    (ci),
    .j    (cj),
    .k    (ck),
    .last (last)
  );

  assign cur_addr = AW'(flat_idx(int'(ci), int'(cj), int'(ck), D1, D2));
  assign wr_addr  = AW'(flat_idx(int'(wr_i), int'(wr_j), int'(wr_k), D1, D2));
  assign rd_addr  = AW'(flat_idx(int'(rd_i), int'(rd_j), int'(rd_k), D1, D2));

  // Non-power-of-two dimensions leave encodable but invalid indices.
  assign wr_ok = (state == IDLE) && wr_en &&
                 (int'(wr_i) < D0) && (int'(wr_j) < D1) && (int'(wr_k) < D2);
  assign rd_ok = (int'(rd_i) < D0) && (int'(rd_j) < D1) && (int'(rd_k) < D2);

  assign rd_data  = rd_ok ? mem[rd_addr] : '0;
  assign elem     = mem[cur_addr];
  assign elem_new = (mode_q == INC_SUM) ? elem + W'(1) : elem;
  assign acc_nxt  = acc + SW'($signed(elem_new));

  // Host writes only land in IDLE, stores only in RUN, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) mem[n] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end else if (run && (mode_q == INC_SUM)) begin
      mem[cur_addr] <= elem_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sum    <= '0;
      mode_q <= SUM;
    end else if (accept) begin
      acc    <= '0;
      mode_q <= fe_mode_t'(mode);
    end else if (run) begin
      acc <= acc_nxt;
      if (last) sum <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/foreach_sum_ctrl.md
# foreach_sum_ctrl

Sequencer that walks a parameterised 3-D register array in row-major `foreach` order, visiting one element per cycle. It accumulates a signed sum of all elements and can optionally increment each element in place before summing it. It is the hardware counterpart of the nested-loop accumulate and load/modify/store patterns exercised by the frontend's `foreach` tests. It sits beside a small register file as its only bulk reader/writer and reports a single result per command.

## Interface
Parameters:
- `D0`, default 2: outer dimension size (index `i`), ≥1.
- `D1`, default 3: middle dimension size (index `j`), ≥1.
- `D2`, default 4: inner dimension size (index `k`), ≥1.
- `W`, default 32: element width, two's-complement signed.
- `SW`, default `W + $clog2(D0*D1*D2+1)`: sum width, signed.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: command request, sampled only in IDLE.
- `mode`, input, 1: command type. 0 = SUM (read-only). 1 = INC_SUM (element += 1, then add the new value).
- `wr_en`, input, 1: host write strobe, effective only in IDLE.
- `wr_i`, `wr_j`, `wr_k`, input, clog2 of each dimension: host write address.
- `wr_data`, input, W: host write data.
- `rd_i`, `rd_j`, `rd_k`, input, clog2 of each dimension: host read address.
- `rd_data`, output, W: combinational read of the addressed element.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle pulse when `sum` becomes valid.
- `sum`, output, SW: result of the last command, held until the next accepted start.

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN on `start`. On entry the index is cleared to (0,0,0), the accumulator is cleared, and `mode` is latched.
- Visit order is row-major: `k` increments fastest. Wrap of `k` carries into `j`, and wrap of `j` carries into `i`.
- Each RUN cycle processes the element at the current (i,j,k):
  - SUM: acc += sign-extend(elem).
  - INC_SUM: new = elem + 1, taken mod 2^W. new is stored, then acc += sign-extend(new).
- The last element is (D0-1, D1-1, D2-1). After it, RUN → DONE, and `sum` is loaded with the final accumulator.
- DONE → IDLE unconditionally after one cycle. `done` is 1 only in DONE.
- Host writes while `busy` are dropped; the array is unchanged. `start` while `busy` is ignored and not queued.
- If `wr_en` and `start` are both high in the same IDLE cycle, the write commits first and the run sees the written value.
- Out-of-range write addresses (index ≥ dimension) are dropped. Out-of-range reads return 0.
- Reset values: state IDLE, `busy` 0, `done` 0, `sum` 0, every array element 0, index 0.
- Reset asserted mid-RUN aborts the command. Elements already incremented stay reset to 0, because the array is reset as well.

## Timing
- `start` is sampled high on edge 0. RUN occupies cycles 1..N, where N = D0·D1·D2. DONE is cycle N+1 with `done`=1, and `sum` is valid from cycle N+1. IDLE resumes at cycle N+2.
- A new `start` is accepted at the earliest on the edge that ends cycle N+1 plus one, i.e. in IDLE. Issue interval is N+2 cycles.
- In INC_SUM, the in-place store of element n commits on the edge that ends RUN cycle n+1.
- `rd_data` reflects any array update one cycle after the committing edge.

## Structure
- Package `foreach_pkg` holds:
  - the state enum `fe_state_t` (IDLE/RUN/DONE);
  - the mode enum `fe_mode_t` (SUM/INC_SUM);
  - a function `flat_idx(i,j,k)` returning i·D1·D2 + j·D2 + k.
- Sub-module `foreach_idx_counter` implements the nested 3-level counter with carry chain.
  - Inputs: `clr`, `en`.
  - Outputs: `i`, `j`, `k`, `last`.
  - Reused for any future N-D walker.
- The array storage and the FSM live in the top module.

## Test plan
- Defaults. Write 1 to (0,2,3) and (1,2,3), all else 0. SUM → `done` at cycle 25, `sum` = 2, array unchanged.
- Same contents, INC_SUM → `sum` = 26. `rd_data` reads 2 at (0,2,3) and (1,2,3), and 1 elsewhere.
- D0=1, D1=1, D2=5, contents {1,2,3,4,5}, INC_SUM → `sum` = 20. Array becomes {2,3,4,5,6}. `done` at cycle 6.
- All 24 elements = -1 (0xFFFFFFFF), SUM → `sum` = -24. Then one element = 0x7FFFFFFF, INC_SUM → that element reads 0x80000000.
- `start` pulsed at cycle 5 of a run, plus `wr_en` during the run → no second `done`, array contents unchanged by the write.
- `rst_n` low at cycle 10 of an INC_SUM run → `busy`, `done` and `sum` all 0 immediately. All elements read 0 after release.
